// File: rtl/delay_sensor_ctrl_if.sv
// Measurement port of the delay-line sensor: request/test inputs from the readout side,
// status and results back from the sensor.
interface delay_sensor_ctrl_if #(
  parameter int STAGES = 11,
  parameter int ACC_W  = 8
);
  // start is a level request sampled only while the sensor is idle (no queuing, no backpressure);
  // busy covers the whole measurement; done is a one-cycle pulse after which meas_sum/last_taps
  // hold until the next accepted start.
  logic              start;
  logic              tst_en;
  logic [STAGES-1:0] tst_taps;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  meas_sum;
  logic [STAGES-1:0] last_taps;

  modport master (
    output start, tst_en, tst_taps,
    input  busy, done, meas_sum, last_taps
  );

  modport slave (
    input  start, tst_en, tst_taps,
    output busy, done, meas_sum, last_taps
  );
endinterface

// File: rtl/delay_sensor_ctrl.sv
// Delay-line timing sensor: launches an edge into a tap chain, thermometer-decodes the captured
// taps and accumulates 2**SAMP_LOG2 samples per measurement, plus a free-running cycle counter.
module delay_sensor_ctrl #(
  parameter  int STAGES    = 11,
  parameter  int CNT_W     = 32,
  parameter  int SAMP_LOG2 = 4,
  localparam int TW        = $clog2(STAGES + 1),
  localparam int ACC_W     = TW + SAMP_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld,
  output logic [CNT_W-1:0]     result,
  output logic                 pathResult,
  output logic [2:0]           o_state,
  delay_sensor_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_ACCUM  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_launch;
  logic [CNT_W-1:0]      r_result;
  logic [STAGES-1:0]     w_taps;
  logic [STAGES-1:0]     r_last_taps;
  logic [ACC_W-1:0]      r_meas_sum;
  logic [SAMP_LOG2-1:0]  r_cnt;
  logic [TW-1:0]         w_therm;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_ACCUM;
      S_ACCUM:  w_next = (&r_cnt) ? S_DONE : S_CLEAR;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Launch is registered so it is high for exactly the cycles spent in LAUNCH.
  always_ff @(posedge clk) begin
    if (rst) r_launch <= 1'b0;
    else     r_launch <= (w_next == S_LAUNCH);
  end

  // Each stage is modelled as a zero-delay buffer; the real delay lives in the sensor fabric.
  always_comb begin : chain
    logic v_prev;
    w_taps = '0;
    v_prev = r_launch;
    for (int k = 0; k < STAGES; k++) begin
      w_taps[k] = v_prev;
      v_prev    = w_taps[k];
    end
  end

  // Count of leading ones from bit 0; the first zero stops it so bubbles are ignored.
  always_comb begin : therm
    logic v_run;
    w_therm = '0;
    v_run   = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (v_run && r_last_taps[i]) w_therm = w_therm + TW'(1);
      else                         v_run   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_taps <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_last_taps <= bus.tst_en ? bus.tst_taps : w_taps;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meas_sum <= '0;
      r_cnt      <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_meas_sum <= '0;
      r_cnt      <= '0;
    end else if (r_state == S_ACCUM) begin
      r_meas_sum <= r_meas_sum + ACC_W'(w_therm);
      if (!(&r_cnt)) r_cnt <= r_cnt + SAMP_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     r_result <= '0;
    else if (ld) r_result <= r_result + CNT_W'(1);
  end

  assign result        = r_result;
  assign pathResult    = w_taps[STAGES-1];
  assign o_state       = r_state;
  assign bus.busy      = (r_state == S_CLEAR) || (r_state == S_LAUNCH) || (r_state == S_ACCUM);
  assign bus.done      = (r_state == S_DONE);
  assign bus.meas_sum  = r_meas_sum;
  assign bus.last_taps = r_last_taps;

endmodule

// File: tb/tb_delay_sensor_ctrl.sv
// Randomised scoreboard bench for delay_sensor_ctrl: measurements are predicted from the
// thermometer rule and checked by a monitor on each done pulse.
module tb_delay_sensor_ctrl;
  localparam int STAGES    = 11;
  localparam int SAMP_LOG2 = 4;
  localparam int N         = 1 << SAMP_LOG2;
  localparam int ACC_W     = $clog2(STAGES + 1) + SAMP_LOG2;
  localparam int W         = ACC_W + STAGES;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [31:0] result;
  logic [3:0]  result4;
  logic        path_result;
  logic        path_result4;
  logic [2:0]  state;
  logic [2:0]  state4;

  delay_sensor_ctrl_if #(.STAGES(STAGES), .ACC_W(ACC_W)) bus  ();
  delay_sensor_ctrl_if #(.STAGES(STAGES), .ACC_W(ACC_W)) bus4 ();

  delay_sensor_ctrl #(.STAGES(STAGES), .CNT_W(32), .SAMP_LOG2(SAMP_LOG2)) dut (
    .clk(clk), .rst(rst), .ld(ld), .result(result), .pathResult(path_result),
    .o_state(state), .bus(bus.slave)
  );

  delay_sensor_ctrl #(.STAGES(STAGES), .CNT_W(4), .SAMP_LOG2(SAMP_LOG2)) dut4 (
    .clk(clk), .rst(rst), .ld(ld), .result(result4), .pathResult(path_result4),
    .o_state(state4), .bus(bus4.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: number of trailing ones of the tap word, counted arithmetically.
  function automatic int ref_therm(input logic [STAGES-1:0] w);
    int v;
    int n;
    v = int'(w);
    n = 0;
    while (v % 2 == 1) begin
      n++;
      v = v / 2;
    end
    return n;
  endfunction

  // Cycle counter reference.
  always @(posedge clk) begin
    if (rst)     exp_cnt = 0;
    else if (ld) exp_cnt = exp_cnt + 1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending measurement");
      end else begin
        e = exp_q.pop_front();
        check("meas_sum", 64'(bus.meas_sum), 64'(e[W-1:STAGES]));
        check("last_taps", 64'(bus.last_taps), 64'(e[STAGES-1:0]));
      end
    end
  end

  task automatic run_meas(input logic te, input logic [STAGES-1:0] tt, input bit extra);
    logic [STAGES-1:0] exp_taps;
    int k;
    int busy_n;
    int path_n;
    exp_taps = te ? tt : {STAGES{1'b1}};
    exp_q.push_back({ACC_W'(N * ref_therm(exp_taps)), exp_taps});
    bus.tst_en   = te;
    bus.tst_taps = tt;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    busy_n = 0;
    path_n = 0;
    while (k < 3 * N + 20) begin
      @(posedge clk);
      #1;
      k++;
      bus.start = extra && (k == 10);
      if (bus.done) break;
      if (bus.busy) busy_n++;
      if (path_result) path_n++;
    end
    check("done_latency", 64'(k), 64'(3 * N));
    check("busy_cycles", 64'(busy_n), 64'(3 * N - 1));
    check("path_high_cycles", 64'(path_n), 64'(N));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(bus.done), 64'(0));
    check("idle_after_done", 64'(bus.busy), 64'(0));
    check("result_count", 64'(result), 64'(32'(exp_cnt)));
  endtask

  initial begin
    logic [STAGES-1:0] tt;
    int n;
    rst = 1'b1;
    ld  = 1'b0;
    bus.start = 1'b0;  bus.tst_en = 1'b0;  bus.tst_taps = '0;
    bus4.start = 1'b0; bus4.tst_en = 1'b0; bus4.tst_taps = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'(0));
    check("rst_result4", 64'(result4), 64'(0));
    check("rst_meas_sum", 64'(bus.meas_sum), 64'(0));
    check("rst_last_taps", 64'(bus.last_taps), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_path", 64'(path_result), 64'(0));

    rst = 1'b0;
    ld  = 1'b1;
    repeat (5) @(posedge clk);
    #1 ld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("count_hold", 64'(result), 64'(5));

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ld = 1'b1;
    repeat (17) @(posedge clk);
    #1 ld = 1'b0;
    check("count_wrap4", 64'(result4), 64'(1));
    check("count_17", 64'(result), 64'(17));
    ld = 1'b1;

    run_meas(1'b1, 11'h07F, 1'b1);
    run_meas(1'b1, 11'h06F, 1'b0);
    run_meas(1'b0, 11'(STAGES'($urandom)), 1'b0);

    for (int r = 0; r < 8; r++) begin
      n  = $urandom_range(0, STAGES);
      tt = STAGES'((1 << n) - 1);
      case ($urandom_range(0, 2))
        0: ;
        1: tt[$urandom_range(0, STAGES - 1)] = 1'b0;
        default: tt = STAGES'($urandom);
      endcase
      run_meas(1'($urandom_range(0, 1)), tt, 1'($urandom_range(0, 1)));
    end

    // Abort mid-measurement: no done may follow.
    bus.tst_en = 1'b1; bus.tst_taps = 11'h07F; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_meas_sum", 64'(bus.meas_sum), 64'(0));
    check("abort_last_taps", 64'(bus.last_taps), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    repeat (3 * N + 5) @(posedge clk);
    #1;
    check("abort_stays_idle", 64'(bus.busy), 64'(0));
    run_meas(1'b1, 11'h3FF, 1'b0);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
